mont_mult_serial: RTL and testbench
===================================

MONT_MULT_SERIAL -- requirements
Module: mont_mult_serial

Interface
REQ-001 SHALL have parameter N, default 512, operand width in bits.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have start  input  1  level request to begin one multiplication.
REQ-005 SHALL have in_a  input  N  multiplicand A, consumed LSB first.
REQ-006 SHALL have in_b  input  N  multiplier B.
REQ-007 SHALL have in_m  input  N  modulus M; caller guarantees M odd, A < M, B < M.
REQ-008 SHALL have result  output  N  registered result A*B*2^-N mod M.
REQ-009 SHALL have done  output  1  level; high while result is valid.

Function
REQ-010 SHALL implement four states: IDLE, LOOP, SUB, DONE.
REQ-011 IDLE: when start=1 at an edge, SHALL latch in_a, in_b, in_m into internal registers, clear accumulator C and iteration counter, and enter LOOP.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Inputs SHALL be sampled only at the IDLE->LOOP edge; later input changes SHALL NOT affect the operation.
REQ-014 LOOP: each cycle SHALL process bit i = counter of latched A: t = C + (a_i ? B : 0); if t[0]=1 then t = t + M; C = t >> 1.
REQ-015 Accumulator and adder path SHALL be N+2 bits wide; no intermediate bit may be truncated.
REQ-016 LOOP SHALL run exactly N cycles (counter 0..N-1), then enter SUB.
REQ-017 SUB: if C >= M then C = C - M, else C unchanged; SHALL take exactly one cycle, then enter DONE.
REQ-018 On entering DONE, result SHALL equal C[N-1:0] and be < M.
REQ-019 Latency: start sampled high at edge E0 -> done high after edge E0+N+1 (513 cycles for N=512).
REQ-020 DONE: done=1 and result SHALL be held stable indefinitely, regardless of start or inputs.
REQ-021 DONE SHALL be left only by resetn=0; a new operation requires reset then start (initiator pulses reset between operations).
REQ-022 done SHALL be 0 in IDLE, LOOP, SUB.
REQ-023 result SHALL be don't-care-free: it holds its last value outside DONE (0 after reset).
REQ-024 start held high continuously from IDLE SHALL launch exactly one operation.

Reset
REQ-025 resetn=0 at an edge SHALL force state=IDLE, done=0, result=0, C=0, counter=0, latched operands=0.
REQ-026 Reset SHALL take priority over start and over any in-progress LOOP/SUB/DONE activity.
REQ-027 resetn=0 mid-LOOP SHALL abort the operation with no done pulse; a subsequent start SHALL run a complete, correct operation.

Verification
REQ-028 N=512, M=13, A=9 (2^512 mod 13), B=5, start held -> done rises exactly 513 cycles after start sample; result=5.
REQ-029 M=13, A=1, B=9 -> result=1; A=0, B=7 -> result=0 (SUB path not taken).
REQ-030 M=2^512-1, A=B=2^512-2 -> result matches reference model; check SUB taken and no overflow in N+2-bit path.
REQ-031 Change in_a/in_b/in_m every cycle after start sample -> result equals model of originally latched values.
REQ-032 Assert resetn=0 at LOOP cycle 200 -> next cycle done=0, result=0, state IDLE; restart with REQ-028 values -> result=5.
REQ-033 Keep start=1 for 2000 cycles after done -> done stays 1, result unchanged, no second operation.

Source files
------------

// File: rtl/mont_mult_serial_if.sv
// ============================================================================
// mont_mult_serial_if : request/response bundle for the serial Montgomery
//                       multiplier (operands, start level, result, done level)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mont_mult_serial_if #(
  parameter int N = 512
);
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;

  modport master (
    output start, in_a, in_b, in_m,
    input  result, done
  );

  modport slave (
    input  start, in_a, in_b, in_m,
    output result, done
  );
endinterface

`default_nettype wire

// File: rtl/mont_mult_serial.sv
// ============================================================================
// mont_mult_serial : bit-serial Montgomery multiplier, result = A*B*2^-N mod M,
//                    one bit of A per cycle followed by a final conditional subtract
// Revision: 1.0
// ============================================================================
`default_nettype none

module mont_mult_serial #(
  parameter int N = 512
) (
  input  logic              clk,
  input  logic              resetn,
  mont_mult_serial_if.slave bus
);

  localparam int               c_cnt_w    = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [N-1:0]         r_a;
  logic [N-1:0]         r_b;
  logic [N-1:0]         r_m;
  logic [N+1:0]         r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N-1:0]         r_result;
  logic                 r_done;

  logic [N+1:0]         w_sum;
  logic [N+1:0]         w_sum_odd;
  logic [N+1:0]         w_t;
  logic [N+1:0]         w_acc_loop;
  logic [N+1:0]         w_acc_sub;
  logic                 w_acc_ge_m;

  // Accumulator stays below 2M, so C + B + M < 4M fits in N+2 bits.
  always_comb begin
    w_sum      = r_acc + (r_a[r_cnt] ? {2'b00, r_b} : {(N+2){1'b0}});
    w_sum_odd  = w_sum + {2'b00, r_m};
    w_t        = w_sum[0] ? w_sum_odd : w_sum;
    w_acc_loop = {1'b0, w_t[N+1:1]};
    w_acc_ge_m = (r_acc >= {2'b00, r_m});
    w_acc_sub  = r_acc - {2'b00, r_m};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = LOOP;
      LOOP:    if (r_cnt == c_cnt_last) w_state_next = SUB;
      SUB:     w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_m   <= bus.in_m;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        LOOP: begin
          r_acc <= w_acc_loop;
          r_cnt <= r_cnt + 1'b1;
        end
        SUB: begin
          if (w_acc_ge_m) begin
            r_acc    <= w_acc_sub;
            r_result <= w_acc_sub[N-1:0];
          end else begin
            r_result <= r_acc[N-1:0];
          end
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mont_mult_serial.sv
// ============================================================================
// tb_mont_mult_serial : randomized self-checking bench for mont_mult_serial
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mont_mult_serial;

  localparam int N     = 512;
  localparam int LAT   = N + 1;
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mont_mult_serial_if #(.N(N)) bus ();

  mont_mult_serial #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Reference: reduce A*B mod M, then divide by two N times in the ring mod M.
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] m);
    logic [2*N-1:0] p;
    logic [N+1:0]   x;
    p = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m};
    x = p[N+1:0];
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = (x + {2'b00, m}) >> 1;
      else      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    resetn    = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Returns after the edge that samples start (E0), plus 1 time unit.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    @(negedge clk);
    bus.in_a  = a;
    bus.in_b  = b;
    bus.in_m  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit hold, input bit scramble, output int cyc);
    cyc = 0;
    while (cyc < BOUND) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (scramble) begin
        bus.in_a = rand_n();
        bus.in_b = rand_n();
        bus.in_m = rand_n();
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.result !== '0) $display("FAIL reset_result: got %h want 0", bus.result);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL idle_hold_done: got %b want 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_known();
    int cyc;
    apply_reset();
    launch(512'd9, 512'd5, 512'd13);
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL known_done_early: got %b want 0", bus.done);
    else n_pass++;
    wait_done(1'b1, 1'b0, cyc);
    n_checks++;
    if (cyc !== LAT) $display("FAIL known_latency: got %0d want %0d", cyc, LAT);
    else n_pass++;
    n_checks++;
    if (bus.result !== 512'd5) $display("FAIL known_result_9x5: got %0d want 5", bus.result);
    else n_pass++;

    apply_reset();
    launch(512'd1, 512'd9, 512'd13);
    wait_done(1'b0, 1'b0, cyc);
    n_checks++;
    if (bus.result !== 512'd1) $display("FAIL known_result_1x9: got %0d want 1", bus.result);
    else n_pass++;

    apply_reset();
    launch(512'd0, 512'd7, 512'd13);
    wait_done(1'b0, 1'b0, cyc);
    n_checks++;
    if (bus.result !== 512'd0 || bus.done !== 1'b1)
      $display("FAIL known_result_0x7: got %0d done %b want 0 done 1", bus.result, bus.done);
    else n_pass++;
  endtask

  task automatic test_max();
    int           cyc;
    logic [N-1:0] m, a, exp;
    m   = '1;
    a   = m - 1'b1;
    exp = model(a, a, m);
    apply_reset();
    launch(a, a, m);
    wait_done(1'b0, 1'b0, cyc);
    n_checks++;
    if (bus.result !== exp) $display("FAIL max_result: got %h want %h", bus.result, exp);
    else n_pass++;
    n_checks++;
    if (!(bus.result < m)) $display("FAIL max_reduced: got %h want below %h", bus.result, m);
    else n_pass++;
  endtask

  task automatic test_random();
    int           cyc;
    logic [N-1:0] m, a, b, exp;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m = {{(N-32){1'b0}}, $urandom | 32'h1};
      else begin
        m = rand_n();
        m[N-1] = 1'b1;
        m[0]   = 1'b1;
      end
      a   = rand_n() % m;
      b   = rand_n() % m;
      exp = model(a, b, m);
      apply_reset();
      launch(a, b, m);
      wait_done(1'b0, 1'b0, cyc);
      n_checks++;
      if (cyc !== LAT) $display("FAIL random_latency[%0d]: got %0d want %0d", i, cyc, LAT);
      else n_pass++;
      n_checks++;
      if (bus.result !== exp) $display("FAIL random_result[%0d]: got %h want %h", i, bus.result, exp);
      else n_pass++;
    end
  endtask

  task automatic test_input_change();
    int           cyc;
    logic [N-1:0] m, a, b, exp;
    m      = rand_n();
    m[N-1] = 1'b1;
    m[0]   = 1'b1;
    a      = rand_n() % m;
    b      = rand_n() % m;
    exp    = model(a, b, m);
    apply_reset();
    launch(a, b, m);
    wait_done(1'b1, 1'b1, cyc);
    n_checks++;
    if (bus.result !== exp) $display("FAIL input_change_result: got %h want %h", bus.result, exp);
    else n_pass++;
  endtask

  task automatic test_reset_midloop();
    int cyc;
    int early;
    apply_reset();
    launch(512'd9, 512'd5, 512'd13);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (199) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.result !== '0)
      $display("FAIL abort_state: got done %b result %0d want 0 0", bus.done, bus.result);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    early  = 0;
    repeat (N + 100) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) early++;
    end
    n_checks++;
    if (early !== 0) $display("FAIL abort_no_done: got %0d done cycles want 0", early);
    else n_pass++;
    launch(512'd9, 512'd5, 512'd13);
    wait_done(1'b1, 1'b0, cyc);
    n_checks++;
    if (cyc !== LAT || bus.result !== 512'd5)
      $display("FAIL restart: got latency %0d result %0d want %0d 5", cyc, bus.result, LAT);
    else n_pass++;
  endtask

  task automatic test_hold();
    int cyc;
    int bad;
    apply_reset();
    launch(512'd9, 512'd5, 512'd13);
    wait_done(1'b1, 1'b0, cyc);
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_a  = rand_n();
      bus.in_b  = rand_n();
      bus.in_m  = rand_n();
      @(posedge clk);
      #1;
      if (bus.done !== 1'b1 || bus.result !== 512'd5) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL hold_done_stable: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  initial begin
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_m  = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_known();
    test_max();
    test_random();
    test_input_change();
    test_reset_midloop();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
